ps2_key_event_ctrl: RTL

Controller that sequences the PS/2 keyboard receiver and turns raw bytes into game key events.
- Synchronises the receiver's scan_ready, captures scan_code and issues the one-cycle read acknowledge.
- Tracks the E0 (extended) and F0 (break) prefixes and maintains held state for the three game keys.
- Queues press events in a small FIFO consumed by the game FSM with a valid/ready handshake.
- Replaces the byte-history compare logic at the keyboard top level.

---
 rtl/ps2_defs.sv | 24 ++
 rtl/ps2_event_fifo.sv | 69 ++++++
 rtl/ps2_key_event_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ps2_defs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_defs: shared byte constants, key codes and FSM encoding for the PS/2  |
// | key event controller.                                          Rev 1.0   |
// +--------------------------------------------------------------------------+
package ps2_defs;

  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;

  localparam logic [7:0] KEY0_DEF = 8'h1C;
  localparam logic [7:0] KEY1_DEF = 8'h1B;
  localparam logic [7:0] KEY2_DEF = 8'h23;

  localparam int KEY_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_CLR = 2'd2
  } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_event_fifo: small synchronous FIFO with registered storage and head   |
// | taken from the read pointer; DEPTH must be a power of two (>= 2). Rev 1.0 |
// +--------------------------------------------------------------------------+
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_key_event_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_key_event_ctrl: acknowledges PS/2 receiver bytes, decodes E0/F0       |
// | prefixes into held key state and queues press events. Optional macro      |
// | PS2_TYPEMATIC_EN turns repeated make codes into events.        Rev 1.0    |
// +--------------------------------------------------------------------------+
module ps2_key_event_ctrl
  import ps2_defs::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] KEY0_CODE  = KEY0_DEF,
  parameter logic [7:0] KEY1_CODE  = KEY1_DEF,
  parameter logic [7:0] KEY2_CODE  = KEY2_DEF
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 scan_ready,
  input  logic [7:0]           scan_code,
  output logic                 read,
  output logic                 ev_valid,
  output logic [KEY_IDX_W-1:0] ev_key,
  input  logic                 ev_ready,
  output logic [2:0]           held,
  output logic                 overflow,
  input  logic                 clr_overflow
);

  ctrl_state_e          state_q, state_d;
  logic                 sr_meta_q, sr_s_q;
  logic                 ext_pend_q, ext_pend_d;
  logic                 brk_pend_q, brk_pend_d;
  logic [2:0]           held_q, held_d;
  logic                 overflow_q, overflow_d;
  logic                 push;
  logic [KEY_IDX_W-1:0] push_key;
  logic                 pop;
  logic                 fifo_full, fifo_empty;
  logic [2:0]           key_hit;

  assign key_hit = {scan_code == KEY2_CODE, scan_code == KEY1_CODE, scan_code == KEY0_CODE};

  always_comb begin
    state_d    = state_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    held_d     = held_q;
    push       = 1'b0;
    push_key   = '0;
    case (state_q)
      IDLE: begin
        if (sr_s_q) begin
          state_d = ACK;
          if (scan_code == PS2_EXT) begin
            ext_pend_d = 1'b1;
          end else if (scan_code == PS2_BRK) begin
            brk_pend_d = 1'b1;
          end else begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
            if (!ext_pend_q) begin
              for (int i = 0; i < 3; i++) begin
                if (key_hit[i]) begin
                  if (brk_pend_q) begin
                    held_d[i] = 1'b0;
                  end else begin
`ifdef PS2_TYPEMATIC_EN
                    push     = 1'b1;
                    push_key = KEY_IDX_W'(i);
`else
                    if (!held_q[i]) begin
                      push     = 1'b1;
                      push_key = KEY_IDX_W'(i);
                    end
`endif
                    held_d[i] = 1'b1;
                  end
                end
              end
            end
          end
        end
      end
      ACK:      state_d = WAIT_CLR;
      // Hold off until the receiver drops its flag so each byte decodes once.
      WAIT_CLR: if (!sr_s_q) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign pop = ev_ready && !fifo_empty;

  always_comb begin
    overflow_d = overflow_q;
    if (clr_overflow) begin
      overflow_d = 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sr_meta_q  <= 1'b0;
      sr_s_q     <= 1'b0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      held_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_meta_q  <= scan_ready;
      sr_s_q     <= sr_meta_q;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      held_q     <= held_d;
      overflow_q <= overflow_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_IDX_W)
  ) u_fifo (
    .clk       (CLOCK_50),
    .rst_n     (resetn),
    .push      (push),
    .push_data (push_key),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (ev_key)
  );

  assign read     = (state_q == ACK);
  assign ev_valid = !fifo_empty;
  assign held     = held_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire
